// File: rtl/uart_alim_tamponu_pkg.sv
// Shared constants and types for the UART receive-side byte buffer.
package uart_alim_tamponu_pkg;

    localparam logic HIGH        = 1'b1;
    localparam logic LOW         = 1'b0;
    localparam int   UART_VERI_W = 8;

    typedef logic [UART_VERI_W-1:0] bayt_t;

endpackage

// File: rtl/uart_fifo_bellek.sv
// Byte storage for the receive FIFO: one synchronous write port, asynchronous read.
module uart_fifo_bellek
    import uart_alim_tamponu_pkg::*;
#(
    parameter int DERINLIK = 16
) (
    input  logic                        clk_i,
    input  logic                        yaz_i,
    input  logic [$clog2(DERINLIK)-1:0] yaz_adr_i,
    input  logic [UART_VERI_W-1:0]      yaz_veri_i,
    input  logic [$clog2(DERINLIK)-1:0] oku_adr_i,
    output logic [UART_VERI_W-1:0]      oku_veri_o
);

    bayt_t r_bellek [DERINLIK];

    // Store the accepted byte at the write pointer.
    // NOTE: the array has no reset; validity is tracked by the pointers and count,
    // so resetting it would only add logic for contents nobody reads.
    always_ff @(posedge clk_i) begin
        if (yaz_i) begin
            r_bellek[yaz_adr_i] <= yaz_veri_i;
        end
    end

    assign oku_veri_o = r_bellek[oku_adr_i];

endmodule

// File: rtl/uart_alim_tamponu.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with sticky overflow,
// threshold/idle-timeout interrupt and software flush.
module uart_alim_tamponu
    import uart_alim_tamponu_pkg::*;
#(
    parameter int DERINLIK    = 16,
    parameter int ESIK        = 8,
    parameter int ZAMAN_ASIMI = 1024
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [UART_VERI_W-1:0]      alinan_veri_i,
    input  logic                        alinan_gecerli_i,
    output logic [UART_VERI_W-1:0]      veri_o,
    output logic                        gecerli_o,
    input  logic                        hazir_i,
    input  logic                        temizle_i,
    output logic [$clog2(DERINLIK):0]   doluluk_o,
    output logic                        dolu_o,
    output logic                        tasma_o,
    output logic                        kesme_o
);

    localparam int AW = $clog2(DERINLIK);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(ZAMAN_ASIMI + 1);

    logic [AW-1:0] r_yaz_ptr;
    logic [AW-1:0] r_oku_ptr;
    logic [CW-1:0] r_doluluk;
    logic [CW-1:0] w_doluluk_next;
    logic [TW-1:0] r_bos_sayac;
    logic [TW-1:0] w_bos_sayac_next;
    logic [TW-1:0] w_sayac_arti;
    logic          r_zaman;
    logic          w_zaman_next;
    logic          r_tasma;
    logic          r_kesme;
    logic          w_bos;
    logic          w_dolu;
    logic          w_pop;
    logic          w_yaz;

    // Flush wins over both pop and write; a full FIFO still accepts a byte when
    // the head leaves in the same cycle.
    assign w_bos        = (r_doluluk == '0);
    assign w_dolu       = (r_doluluk == CW'(DERINLIK));
    assign w_pop        = ~w_bos & hazir_i & ~temizle_i;
    assign w_yaz        = alinan_gecerli_i & (~w_dolu | w_pop) & ~temizle_i;
    assign w_sayac_arti = r_bos_sayac + TW'(1);

    uart_fifo_bellek #(
        .DERINLIK   (DERINLIK)
    ) u_bellek (
        .clk_i      (clk_i),
        .yaz_i      (w_yaz),
        .yaz_adr_i  (r_yaz_ptr),
        .yaz_veri_i (alinan_veri_i),
        .oku_adr_i  (r_oku_ptr),
        .oku_veri_o (veri_o)
    );

    // Next byte count: +1 write only, -1 pop only, cleared by flush.
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_doluluk_next = r_doluluk;
        if (temizle_i) begin
            w_doluluk_next = '0;
        end else if (w_yaz && !w_pop) begin
            w_doluluk_next = r_doluluk + CW'(1);
        end else if (w_pop && !w_yaz) begin
            w_doluluk_next = r_doluluk - CW'(1);
        end
    end

    // Idle timer: restarts on any strobe or while empty, saturates at ZAMAN_ASIMI.
    always_comb begin
        w_bos_sayac_next = r_bos_sayac;
        w_zaman_next     = r_zaman;
        if (temizle_i || alinan_gecerli_i || w_bos) begin
            w_bos_sayac_next = '0;
            w_zaman_next     = LOW;
        end else if (r_bos_sayac != TW'(ZAMAN_ASIMI)) begin
            w_bos_sayac_next = w_sayac_arti;
            if (w_sayac_arti == TW'(ZAMAN_ASIMI)) begin
                w_zaman_next = HIGH;
            end
        end
        if (w_doluluk_next == '0) begin
            w_zaman_next = LOW;
        end
    end

    // Pointers, count, sticky overflow, timeout flag and registered interrupt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_yaz_ptr   <= '0;
            r_oku_ptr   <= '0;
            r_doluluk   <= '0;
            r_bos_sayac <= '0;
            r_zaman     <= LOW;
            r_tasma     <= LOW;
            r_kesme     <= LOW;
        end else begin
            if (temizle_i) begin
                r_yaz_ptr <= '0;
                r_oku_ptr <= '0;
            end else begin
                if (w_yaz) r_yaz_ptr <= r_yaz_ptr + AW'(1);
                if (w_pop) r_oku_ptr <= r_oku_ptr + AW'(1);
            end
            if (temizle_i) begin
                r_tasma <= LOW;
            end else if (alinan_gecerli_i && !w_yaz) begin
                r_tasma <= HIGH;
            end
            r_doluluk   <= w_doluluk_next;
            r_bos_sayac <= w_bos_sayac_next;
            r_zaman     <= w_zaman_next;
            r_kesme     <= (w_doluluk_next >= CW'(ESIK)) | w_zaman_next;
        end
    end

    assign doluluk_o = r_doluluk;
    assign gecerli_o = ~w_bos;
    assign dolu_o    = w_dolu;
    assign tasma_o   = r_tasma;
    assign kesme_o   = r_kesme;

endmodule
